// File: rtl/bp_be_cache_req_arbiter.sv
// Round-robin arbiter sharing the single D$-to-LCE cache request channel among BE requesters.
// The channel is held for one transaction at a time: accept, one metadata beat, then wait for completion.
module bp_be_cache_req_arbiter #(
  parameter int num_req_p        = 2,
  parameter int req_width_p      = 64,
  parameter int metadata_width_p = 8,
  parameter int timeout_cycles_p = 1024,
  localparam int gw_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1,
  localparam int cw_lp = $clog2(timeout_cycles_p + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [num_req_p*req_width_p-1:0]      req_i,
  input  logic [num_req_p-1:0]                  req_v_i,
  output logic [num_req_p-1:0]                  req_ready_o,
  input  logic [num_req_p*metadata_width_p-1:0] meta_i,
  output logic [num_req_p-1:0]                  complete_o,
  output logic [req_width_p-1:0]                cache_req_o,
  output logic                                  cache_req_v_o,
  input  logic                                  cache_req_ready_i,
  output logic [metadata_width_p-1:0]           cache_req_metadata_o,
  output logic                                  cache_req_metadata_v_o,
  input  logic                                  cache_req_complete_i,
  output logic                                  busy_o,
  output logic [gw_lp-1:0]                      grant_id_o,
  output logic                                  timeout_o
);

  localparam logic [gw_lp-1:0] last_lp = gw_lp'(num_req_p - 1);
  localparam logic [cw_lp-1:0] to_lp   = cw_lp'(timeout_cycles_p);

  typedef enum logic [1:0] {E_IDLE, E_META, E_WAIT} state_e;

  state_e                      state_q, state_d;
  logic [gw_lp-1:0]            rr_q, rr_d, grant_q, grant_d, sel, cand, rr_next;
  logic [metadata_width_p-1:0] meta_q, meta_d;
  logic [cw_lp-1:0]            cnt_q, cnt_d;
  logic                        timeout_q, timeout_d;
  logic                        found;
  int                          idx;

  logic [num_req_p-1:0][req_width_p-1:0]      req_a;
  logic [num_req_p-1:0][metadata_width_p-1:0] meta_a;
  assign req_a  = req_i;
  assign meta_a = meta_i;

  // First valid requester at or after rr_q, wrapping
  always_comb begin
    sel   = rr_q;
    cand  = rr_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < num_req_p; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= num_req_p) idx = idx - num_req_p;
      cand = gw_lp'(idx);
      if (!found && req_v_i[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign rr_next = (grant_q == last_lp) ? '0 : grant_q + gw_lp'(1);

  always_comb begin
    state_d                = state_q;
    rr_d                   = rr_q;
    grant_d                = grant_q;
    meta_d                 = meta_q;
    cnt_d                  = cnt_q;
    timeout_d              = timeout_q;
    cache_req_v_o          = 1'b0;
    req_ready_o            = '0;
    cache_req_metadata_v_o = 1'b0;
    complete_o             = '0;
    unique case (state_q)
      E_IDLE: begin
        cache_req_v_o    = |req_v_i;
        req_ready_o[sel] = cache_req_ready_i;
        if (cache_req_v_o && cache_req_ready_i) begin
          grant_d = sel;
          meta_d  = meta_a[sel];
          state_d = E_META;
        end
      end
      E_META: begin
        cache_req_metadata_v_o = 1'b1;
        state_d                = E_WAIT;
        if (cache_req_complete_i) begin
          complete_o[grant_q] = 1'b1;
          rr_d                = rr_next;
          state_d             = E_IDLE;
        end
      end
      E_WAIT: begin
        if (cache_req_complete_i) begin
          complete_o[grant_q] = 1'b1;
          cnt_d               = '0;
          rr_d                = rr_next;
          state_d             = E_IDLE;
        end else begin
          if (cnt_q != to_lp) cnt_d = cnt_q + cw_lp'(1);
          timeout_d = timeout_q | (cnt_d == to_lp);
        end
      end
      default: state_d = E_IDLE;
    endcase
    // The IDLE outputs are combinational from the requesters; keep them quiet while reset is held
    if (reset_i) begin
      cache_req_v_o          = 1'b0;
      req_ready_o            = '0;
      cache_req_metadata_v_o = 1'b0;
      complete_o             = '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= E_IDLE;
      rr_q      <= '0;
      grant_q   <= '0;
      meta_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      meta_q    <= meta_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign cache_req_o          = (state_q == E_IDLE && !reset_i) ? req_a[sel] : '0;
  assign cache_req_metadata_o = meta_q;
  assign busy_o               = (state_q != E_IDLE);
  assign grant_id_o           = grant_q;
  assign timeout_o            = timeout_q;

endmodule
